// File: rtl/frog_move_ctrl_if.sv
// rtl/frog_move_ctrl_if.sv - Signal bundle between the game layer and the frog movement controller
interface frog_move_ctrl_if;
   logic       frame_tick;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       collision;
   logic [9:0] frog_x;
   logic [9:0] frog_y;
   logic       hop_active;
   logic       dead;
   logic [1:0] lives;
   logic [7:0] score;
   logic       game_over;

   modport master (
      output frame_tick, btn_up, btn_down, btn_left, btn_right, collision,
      input  frog_x, frog_y, hop_active, dead, lives, score, game_over
   );

   modport slave (
      input  frame_tick, btn_up, btn_down, btn_left, btn_right, collision,
      output frog_x, frog_y, hop_active, dead, lives, score, game_over
   );
endinterface

// File: rtl/frog_move_ctrl.sv
// rtl/frog_move_ctrl.sv - Frog hop/death/respawn/score sequencer for the VGA sprite layer
// Optional macro FROG_SMOOTH_HOP_EN: animate each hop over HOP_FRAMES frames instead of one.
module frog_move_ctrl #(
   parameter int GRID        = 32,
   parameter int X_MAX       = 608,
   parameter int Y_MAX       = 448,
   parameter int START_X     = 304,
   parameter int START_Y     = 448,
   parameter int HOP_FRAMES  = 8,
   parameter int DEAD_FRAMES = 30,
   parameter int START_LIVES = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   frog_move_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_HOP, S_DEAD, S_OVER} state_t;

   localparam int DW = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;
`ifdef FROG_SMOOTH_HOP_EN
   localparam int SW = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;
   localparam logic signed [10:0] C_STEP = 11'(GRID / HOP_FRAMES);
`else
   localparam logic signed [10:0] C_STEP = 11'(GRID);
`endif
   localparam logic signed [10:0] C_GRID    = 11'(GRID);
   localparam logic signed [10:0] C_X_MAX   = 11'(X_MAX);
   localparam logic signed [10:0] C_Y_MAX   = 11'(Y_MAX);
   localparam logic [9:0]         C_START_X = 10'(START_X);
   localparam logic [9:0]         C_START_Y = 10'(START_Y);
   localparam logic [1:0]         C_LIVES   = 2'(START_LIVES);

   localparam logic [1:0] D_UP    = 2'd0;
   localparam logic [1:0] D_DOWN  = 2'd1;
   localparam logic [1:0] D_LEFT  = 2'd2;
   localparam logic [1:0] D_RIGHT = 2'd3;

   state_t        r_state;
   logic [3:0]    r_btn_s1;
   logic [3:0]    r_btn_s2;
   logic [3:0]    r_btn_prev;
   logic [1:0]    r_dir;
   logic [9:0]    r_x;
   logic [9:0]    r_y;
   logic          r_hop_active;
   logic          r_dead;
   logic          r_game_over;
   logic [1:0]    r_lives;
   logic [7:0]    r_score;
   logic [DW-1:0] r_dead_cnt;
`ifdef FROG_SMOOTH_HOP_EN
   logic [SW-1:0] r_step;
`endif

   logic [3:0]         w_btn_raw;
   logic [3:0]         w_press;
   logic               w_one_press;
   logic [1:0]         w_press_dir;
   logic signed [10:0] w_x_s;
   logic signed [10:0] w_y_s;
   logic signed [10:0] w_tgt_x;
   logic signed [10:0] w_tgt_y;
   logic signed [10:0] w_nx;
   logic signed [10:0] w_ny;
   logic               w_in_bounds;
   logic               w_hop_last;

   // Button vector order: {up, down, left, right}
   assign w_btn_raw   = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
   assign w_press     = r_btn_s2 & ~r_btn_prev;
   assign w_one_press = (w_press == 4'b1000) || (w_press == 4'b0100) ||
                        (w_press == 4'b0010) || (w_press == 4'b0001);
   assign w_x_s       = {1'b0, r_x};
   assign w_y_s       = {1'b0, r_y};

   always_comb begin
      w_press_dir = D_RIGHT;
      case (w_press)
         4'b1000: w_press_dir = D_UP;
         4'b0100: w_press_dir = D_DOWN;
         4'b0010: w_press_dir = D_LEFT;
         default: w_press_dir = D_RIGHT;
      endcase

      // Bounds are always judged on the full-cell landing spot, not one step.
      w_tgt_x = w_x_s;
      w_tgt_y = w_y_s;
      case (w_press_dir)
         D_UP:    w_tgt_y = w_y_s - C_GRID;
         D_DOWN:  w_tgt_y = w_y_s + C_GRID;
         D_LEFT:  w_tgt_x = w_x_s - C_GRID;
         default: w_tgt_x = w_x_s + C_GRID;
      endcase

      w_nx = w_x_s;
      w_ny = w_y_s;
      case (r_dir)
         D_UP:    w_ny = w_y_s - C_STEP;
         D_DOWN:  w_ny = w_y_s + C_STEP;
         D_LEFT:  w_nx = w_x_s - C_STEP;
         default: w_nx = w_x_s + C_STEP;
      endcase
   end

   assign w_in_bounds = (w_tgt_x >= 11'sd0) && (w_tgt_x <= C_X_MAX) &&
                        (w_tgt_y >= 11'sd0) && (w_tgt_y <= C_Y_MAX);

`ifdef FROG_SMOOTH_HOP_EN
   assign w_hop_last = (r_step == SW'(HOP_FRAMES - 1));
`else
   assign w_hop_last = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_btn_s1     <= '0;
         r_btn_s2     <= '0;
         r_btn_prev   <= '0;
         r_dir        <= D_UP;
         r_x          <= C_START_X;
         r_y          <= C_START_Y;
         r_hop_active <= 1'b0;
         r_dead       <= 1'b0;
         r_game_over  <= 1'b0;
         r_lives      <= C_LIVES;
         r_score      <= '0;
         r_dead_cnt   <= '0;
`ifdef FROG_SMOOTH_HOP_EN
         r_step       <= '0;
`endif
      end else begin
         r_btn_s1 <= w_btn_raw;
         r_btn_s2 <= r_btn_s1;
         if (bus.frame_tick) begin
            r_btn_prev <= r_btn_s2;
         end

         case (r_state)
            S_IDLE, S_HOP: begin
               if (bus.collision) begin
                  r_hop_active <= 1'b0;
                  r_dead_cnt   <= '0;
                  if (r_lives <= 2'd1) begin
                     r_lives     <= 2'd0;
                     r_state     <= S_OVER;
                     r_game_over <= 1'b1;
                  end else begin
                     r_lives <= r_lives - 2'd1;
                     r_state <= S_DEAD;
                     r_dead  <= 1'b1;
                  end
               end else if (bus.frame_tick) begin
                  if (r_state == S_IDLE) begin
                     if (w_one_press && w_in_bounds) begin
                        r_dir        <= w_press_dir;
                        r_state      <= S_HOP;
                        r_hop_active <= 1'b1;
`ifdef FROG_SMOOTH_HOP_EN
                        r_step       <= '0;
`endif
                     end
                  end else begin
`ifdef FROG_SMOOTH_HOP_EN
                     r_step <= r_step + 1'b1;
`endif
                     if (w_hop_last) begin
                        r_state      <= S_IDLE;
                        r_hop_active <= 1'b0;
                     end
                     // Reaching the top row scores and sends the frog home on the same edge.
                     if (w_hop_last && (w_ny == 11'sd0)) begin
                        if (r_score != 8'hFF) begin
                           r_score <= r_score + 8'd1;
                        end
                        r_x <= C_START_X;
                        r_y <= C_START_Y;
                     end else begin
                        r_x <= w_nx[9:0];
                        r_y <= w_ny[9:0];
                     end
                  end
               end
            end
            S_DEAD: begin
               if (bus.frame_tick) begin
                  if (r_dead_cnt == DW'(DEAD_FRAMES - 1)) begin
                     r_state <= S_IDLE;
                     r_dead  <= 1'b0;
                     r_x     <= C_START_X;
                     r_y     <= C_START_Y;
                  end else begin
                     r_dead_cnt <= r_dead_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_OVER;
            end
         endcase
      end
   end

   assign bus.frog_x     = r_x;
   assign bus.frog_y     = r_y;
   assign bus.hop_active = r_hop_active;
   assign bus.dead       = r_dead;
   assign bus.lives      = r_lives;
   assign bus.score      = r_score;
   assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_frog_move_ctrl.sv
// tb/tb_frog_move_ctrl.sv - Directed self-checking bench for frog_move_ctrl
module tb_frog_move_ctrl;

`ifdef FROG_SMOOTH_HOP_EN
   localparam int HN = 8;
`else
   localparam int HN = 1;
`endif
   localparam int STEP = 32 / HN;

   localparam logic [3:0] B_UP    = 4'b1000;
   localparam logic [3:0] B_DOWN  = 4'b0100;
   localparam logic [3:0] B_LEFT  = 4'b0010;
   localparam logic [3:0] B_RIGHT = 4'b0001;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   frog_move_ctrl_if bus_if ();

   frog_move_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_btn(input logic [3:0] b);
      bus_if.btn_up    = b[3];
      bus_if.btn_down  = b[2];
      bus_if.btn_left  = b[1];
      bus_if.btn_right = b[0];
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic tick();
      @(negedge clk);
      bus_if.frame_tick = 1'b1;
      @(negedge clk);
      bus_if.frame_tick = 1'b0;
   endtask

   task automatic collide(input logic with_tick);
      @(negedge clk);
      bus_if.collision  = 1'b1;
      bus_if.frame_tick = with_tick;
      @(negedge clk);
      bus_if.collision  = 1'b0;
      bus_if.frame_tick = 1'b0;
   endtask

   task automatic hop(input logic [3:0] b);
      set_btn(b);
      settle();
      tick();
      set_btn(4'b0000);
      settle();
      repeat (HN) tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n = 1'b0;
      bus_if.frame_tick = 1'b0;
      bus_if.collision  = 1'b0;
      set_btn(4'b0000);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      chk("rst_x", bus_if.frog_x, 304);
      chk("rst_y", bus_if.frog_y, 448);
      chk("rst_lives", bus_if.lives, 3);
      chk("rst_score", bus_if.score, 0);
      chk("rst_hop", bus_if.hop_active, 0);
      chk("rst_dead", bus_if.dead, 0);
      chk("rst_over", bus_if.game_over, 0);

      // Down from the bottom row is out of bounds.
      set_btn(B_DOWN);
      settle();
      tick();
      chk("down_hop", bus_if.hop_active, 0);
      tick();
      chk("down_y", bus_if.frog_y, 448);
      set_btn(4'b0000);
      settle();
      tick();

      set_btn(B_LEFT | B_RIGHT);
      settle();
      tick();
      chk("multi_hop", bus_if.hop_active, 0);
      tick();
      chk("multi_x", bus_if.frog_x, 304);
      set_btn(4'b0000);
      settle();
      tick();

      set_btn(B_UP);
      settle();
      tick();
      chk("up_enter_hop", bus_if.hop_active, 1);
      chk("up_enter_y", bus_if.frog_y, 448);
      set_btn(4'b0000);
      settle();
      for (int i = 1; i <= HN; i++) begin
         tick();
         chk("up_step_y", bus_if.frog_y, 448 - i * STEP);
         chk("up_step_hop", bus_if.hop_active, (i < HN) ? 1 : 0);
      end
      chk("up_x", bus_if.frog_x, 304);

      hop(B_LEFT);
      chk("left_x", bus_if.frog_x, 272);
      chk("left_y", bus_if.frog_y, 416);

      hop(B_RIGHT);
      chk("right_x", bus_if.frog_x, 304);

      // Collision coincident with a frame tick mid-hop: no step that cycle.
      set_btn(B_UP);
      settle();
      tick();
      set_btn(4'b0000);
      settle();
      if (HN > 1) repeat (2) tick();
      collide(1'b1);
      chk("coll_y", bus_if.frog_y, 416 - ((HN > 1) ? 2 * STEP : 0));
      chk("coll_dead", bus_if.dead, 1);
      chk("coll_lives", bus_if.lives, 2);
      chk("coll_hop", bus_if.hop_active, 0);
      collide(1'b0);
      chk("dead_ignore_lives", bus_if.lives, 2);
      repeat (29) tick();
      chk("dead_29_dead", bus_if.dead, 1);
      chk("dead_29_y", bus_if.frog_y, 416 - ((HN > 1) ? 2 * STEP : 0));
      tick();
      chk("respawn_dead", bus_if.dead, 0);
      chk("respawn_x", bus_if.frog_x, 304);
      chk("respawn_y", bus_if.frog_y, 448);

      for (int i = 0; i < 13; i++) hop(B_UP);
      chk("pre_goal_y", bus_if.frog_y, 32);
      chk("pre_goal_score", bus_if.score, 0);
      hop(B_UP);
      chk("goal_score", bus_if.score, 1);
      chk("goal_x", bus_if.frog_x, 304);
      chk("goal_y", bus_if.frog_y, 448);
      chk("goal_hop", bus_if.hop_active, 0);

      collide(1'b0);
      chk("coll2_lives", bus_if.lives, 1);
      chk("coll2_dead", bus_if.dead, 1);
      repeat (30) tick();
      chk("coll2_respawn", bus_if.dead, 0);
      collide(1'b0);
      chk("over_lives", bus_if.lives, 0);
      chk("over_flag", bus_if.game_over, 1);
      chk("over_dead", bus_if.dead, 0);

      set_btn(B_UP);
      settle();
      tick();
      collide(1'b1);
      set_btn(4'b0000);
      settle();
      repeat (3) tick();
      chk("over_hold_x", bus_if.frog_x, 304);
      chk("over_hold_y", bus_if.frog_y, 448);
      chk("over_hold_hop", bus_if.hop_active, 0);
      chk("over_hold_lives", bus_if.lives, 0);
      chk("over_hold_score", bus_if.score, 1);
      chk("over_hold_flag", bus_if.game_over, 1);

      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst2_lives", bus_if.lives, 3);
      chk("rst2_score", bus_if.score, 0);
      chk("rst2_over", bus_if.game_over, 0);

      // Asynchronous reset in the middle of a hop, checked before any clock edge.
      set_btn(B_UP);
      settle();
      tick();
      set_btn(4'b0000);
      settle();
      if (HN > 1) tick();
      chk("mid_hop_active", bus_if.hop_active, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_hop", bus_if.hop_active, 0);
      chk("async_rst_y", bus_if.frog_y, 448);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
